// File: rtl/md_unit.sv
// EX-stage multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at start and committed after a fixed busy latency.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t         state, state_next;
   logic [CW-1:0]  cnt;
   logic [31:0]    pend_hi, pend_lo;
   logic           pend_wr;

   logic           launch;
   logic [31:0]    res_hi, res_lo;
   logic           res_wr;
   logic [CW-1:0]  res_cycles;

   logic [63:0]    prod_s, prod_u;
   logic [31:0]    a_mag, b_mag, b_div, q_mag, r_mag;
   logic [31:0]    q_s, r_s;

   // mult/multu/div/divu all have md_op[2] clear
   assign launch = start && !md_op[2];

   // Signed division works on magnitudes so 0x80000000 / -1 needs no special case.
   always_comb begin
      prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
      prod_u = {32'b0, op_a} * {32'b0, op_b};
      a_mag  = (md_op == OP_DIV && op_a[31]) ? (~op_a + 32'd1) : op_a;
      b_mag  = (md_op == OP_DIV && op_b[31]) ? (~op_b + 32'd1) : op_b;
      b_div  = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag  = a_mag / b_div;
      r_mag  = a_mag % b_div;
      q_s    = (op_a[31] ^ op_b[31]) ? (~q_mag + 32'd1) : q_mag;
      r_s    = op_a[31] ? (~r_mag + 32'd1) : r_mag;
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      res_hi     = 32'd0;
      res_lo     = 32'd0;
      res_wr     = 1'b1;
      res_cycles = CW'(MULT_CYCLES);
      case (md_op)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            res_hi     = r_s;
            res_lo     = q_s;
            res_wr     = (op_b != 32'd0);
            res_cycles = CW'(DIV_CYCLES);
         end
         OP_DIVU: begin
            res_hi     = r_mag;
            res_lo     = q_mag;
            res_wr     = (op_b != 32'd0);
            res_cycles = CW'(DIV_CYCLES);
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (launch) state_next = RUN;
         RUN:     if (cnt == CW'(1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
   end

   // NOTE: every register here, including the pending result, is cleared by reset
   // so an aborted operation can never commit after release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
         hi      <= 32'd0;
         lo      <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (launch) begin
                     pend_hi <= res_hi;
                     pend_lo <= res_lo;
                     pend_wr <= res_wr;
                     cnt     <= res_cycles;
                  end else if (md_op == OP_MTHI) begin
                     hi <= op_a;
                  end else if (md_op == OP_MTLO) begin
                     lo <= op_a;
                  end
               end
            end
            RUN: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1) && pend_wr) begin
                  hi <= pend_hi;
                  lo <= pend_lo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: scoreboard queue of expected HI/LO results
// popped by a monitor on each busy falling edge, against an arithmetic model.
module tb_md_unit;

   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] op_a, op_b;
   logic        busy;
   logic [31:0] hi, lo;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      int          cycles;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_hi, m_lo;

   md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
      .clk(clk), .reset(reset), .start(start), .md_op(md_op),
      .op_a(op_a), .op_b(op_b), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference result {hi,lo}; valid flag is 0 for divide by zero.
   function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         3'd0: return {1'b1, 64'(sa * sb)};
         3'd1: return {1'b1, ua * ub};
         3'd2: begin
            if (b == 0) return {1'b0, 64'd0};
            q = sa / sb;
            r = sa % sb;
            return {1'b1, r[31:0], q[31:0]};
         end
         3'd3: begin
            if (b == 0) return {1'b0, 64'd0};
            return {1'b1, 32'(ua % ub), 32'(ua / ub)};
         end
         default: return {1'b0, 64'd0};
      endcase
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         errors++;
         $display("FAIL timeout: busy still 1 after %0d cycles expected 0", n);
      end
   endtask

   // Drive one start pulse; the scoreboard/model is updated for legal issues.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [64:0] r;
      exp_t        e;
      @(negedge clk);
      start = 1'b1;
      md_op = op;
      op_a  = a;
      op_b  = b;
      if (!op[2]) begin
         r = model(op, a, b);
         e.old_hi = m_hi;
         e.old_lo = m_lo;
         if (r[64]) begin
            m_hi = r[63:32];
            m_lo = r[31:0];
         end
         e.exp_hi = m_hi;
         e.exp_lo = m_lo;
         e.cycles = op[1] ? DIV_CYCLES : MULT_CYCLES;
         sb_q.push_back(e);
      end else if (op == 3'b100) begin
         m_hi = a;
      end else if (op == 3'b101) begin
         m_lo = a;
      end
      @(negedge clk);
      start = 1'b0;
      if (op[2]) begin
         check("mt_busy", {31'b0, busy}, 32'd0);
         check("mt_hi", hi, m_hi);
         check("mt_lo", lo, m_lo);
      end
   endtask

   // Monitor: counts busy length, checks HI/LO hold during RUN, pops on completion.
   initial begin : monitor
      int   run_len = 0;
      logic prev_busy = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            run_len   = 0;
            prev_busy = 1'b0;
         end else begin
            if (busy) begin
               run_len++;
               if (sb_q.size() > 0) begin
                  check("hold_hi", hi, sb_q[0].old_hi);
                  check("hold_lo", lo, sb_q[0].old_lo);
               end
            end else if (prev_busy) begin
               if (sb_q.size() == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL unexpected_done: got completion expected none");
               end else begin
                  e = sb_q.pop_front();
                  check("busy_len", 32'(run_len), 32'(e.cycles));
                  check("res_hi", hi, e.exp_hi);
                  check("res_lo", lo, e.exp_lo);
               end
               run_len = 0;
            end
            prev_busy = busy;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : stim
      logic [2:0]  op;
      logic [31:0] a, b;
      reset = 1'b1;
      start = 1'b0;
      md_op = 3'd0;
      op_a  = 32'd0;
      op_b  = 32'd0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      reset = 1'b0;

      issue(3'd0, 32'hFFFF_FFFF, 32'h2); wait_idle();
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFFE);
      issue(3'd1, 32'hFFFF_FFFF, 32'h2); wait_idle();
      check("multu_hi", hi, 32'h0000_0001);
      issue(3'd2, 32'hFFFF_FFF9, 32'h2); wait_idle();
      check("div_lo", lo, 32'hFFFF_FFFD);
      check("div_hi", hi, 32'hFFFF_FFFF);
      issue(3'd3, 32'hFFFF_FFF9, 32'h2); wait_idle();
      check("divu_lo", lo, 32'h7FFF_FFFC);
      check("divu_hi", hi, 32'h0000_0001);
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
      check("ovf_lo", lo, 32'h8000_0000);
      check("ovf_hi", hi, 32'h0);

      issue(3'd4, 32'h1234_5678, 32'h0);
      issue(3'd5, 32'h9ABC_DEF0, 32'h0);
      issue(3'd3, 32'h7, 32'h0); wait_idle();
      check("dz_hi", hi, 32'h1234_5678);
      check("dz_lo", lo, 32'h9ABC_DEF0);
      issue(3'd6, 32'hDEAD_BEEF, 32'h1);
      issue(3'd7, 32'hDEAD_BEEF, 32'h1);

      // start during RUN must be ignored
      issue(3'd2, 32'd100, 32'd3);
      repeat (2) @(negedge clk);
      start = 1'b1; md_op = 3'd0; op_a = 32'd5; op_b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      check("ign_lo", lo, 32'd33);
      check("ign_hi", hi, 32'd1);

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 9) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         issue(op, a, b);
         wait_idle();
      end

      // Async reset in the middle of a divide
      issue(3'd4, 32'hCAFE_0001, 32'h0);
      issue(3'd2, 32'd1000, 32'd7);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_busy", {31'b0, busy}, 32'd0);
      check("arst_hi", hi, 32'd0);
      check("arst_lo", lo, 32'd0);
      sb_q.delete();
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check("post_rst_state", {busy, hi[30:0]} | lo, 32'd0);
      end
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the MIPS pipeline.
- Operands are the register-file read values carried through the ID/EX register (rs to op_a, rt to op_b).
- Holds the architectural HI/LO registers. mfhi/mflo read them, and the write-back path returns them to the register file.
- Models fixed multi-cycle latency with a busy flag, which the hazard unit uses to stall md-class instructions in D.

Parameters:
MULT_CYCLES, 5, cycles busy is held for mult/multu (must be >= 1)
DIV_CYCLES, 10, cycles busy is held for div/divu (must be >= 1)

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  EX-stage md instruction valid this cycle
md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others reserved (no-op)
op_a  input  32  rs operand
op_b  input  32  rt operand
busy  output  1  registered; 1 while a mult/div is in progress
hi  output  32  current HI register
lo  output  32  current LO register

Behaviour:
- Interface (already decided): one clock, clk. Reset is reset, asynchronous and active-high.
- Reset:
  - busy=0, hi=0, lo=0, cycle counter=0, pending result registers=0.
  - Reset asserted mid-operation aborts the operation. No result is written after reset releases.
- State machine:
  - IDLE (busy=0) and RUN (busy=1). The counter is 4 bits minimum, wide enough for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, start=1 with mult/multu/div/divu at edge E0:
  - Capture the computed 64-bit result into pending registers.
  - Load counter with N (MULT_CYCLES or DIV_CYCLES). Go to RUN, busy=1.
- RUN, each edge: counter decrements.
  - At the edge where the counter is 1, commit pending to hi/lo, set busy=0, return to IDLE.
  - busy is therefore high for exactly N cycles after E0. New hi/lo are visible in the cycle after edge E0+N, the same cycle busy reads 0.
- mthi/mtlo in IDLE with start=1: hi<=op_a (or lo<=op_a) at that edge. busy stays 0. The other register is unchanged.
- Reserved md_op with start=1: no state change.
- start=1 while busy=1: ignored. The pending operation continues unaffected. The hazard unit guarantees this never happens legally, so the bench checks only the no-corruption property.
- Arithmetic:
  - mult: signed 32x32 to 64, {hi,lo}=product.
  - multu: the same, unsigned.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (op_b=0, div or divu):
  - busy runs the full DIV_CYCLES.
  - hi/lo are NOT updated at completion and keep their pre-start values.
- hi/lo outputs are plain register outputs, with no bypass of the pending result.
- Nothing else in the unit changes hi/lo during RUN.

Test Plan:
- Reset, then mult with op_a=0xFFFFFFFF, op_b=0x00000002, start at E0:
  - busy=1 for 5 cycles.
  - After E5: hi=0xFFFFFFFF, lo=0xFFFFFFFE, busy=0.
- multu with the same operands: after 5 cycles hi=0x00000001, lo=0xFFFFFFFE. Also check that hi/lo hold their old values during cycles 1..4.
- div with op_a=0xFFFFFFF9 (-7), op_b=2:
  - busy for 10 cycles.
  - Result lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - divu on the same operands: lo=0x7FFFFFFC, hi=0x00000001.
- mthi op_a=0x12345678, next cycle mtlo op_a=0x9ABCDEF0:
  - hi/lo update on the respective edges, busy never asserts.
  - Then divu 7/0: busy for 10 cycles, hi/lo remain 0x12345678/0x9ABCDEF0.
- Start div 100/3. Assert a start=1 mult with 5*5 at cycle 3 of RUN: it is ignored, result lo=33, hi=1.
- Async reset: start div, then assert reset mid-cycle at cycle 4:
  - busy, hi and lo go to 0 without waiting for a clock edge.
  - After release, no commit occurs at the old completion time.
